// File: rtl/data_mem_sync_if.sv
// Request/response bundle for data_mem_sync: master issues MEM-stage accesses, slave is the memory.
interface data_mem_sync_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] addr_in;
  logic [1:0]        size;
  logic              sign_ext;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;
  logic              resp_valid;
  logic              err;

  modport master (
    output req_valid, mem_rd, mem_wr, addr_in, size, sign_ext, wr_data,
    input  req_ready, rd_data, resp_valid, err
  );

  modport slave (
    input  req_valid, mem_rd, mem_wr, addr_in, size, sign_ext, wr_data,
    output req_ready, rd_data, resp_valid, err
  );
endinterface

// File: rtl/data_mem_sync.sv
// data_mem_sync: big-endian byte RAM, one access in flight; DATA_MEM_ALIGN_CHK_EN turns misalignment into an error.
// resp_valid WAIT_CYCLES+1 cycles after accept; req_ready low from accept until the RESP cycle ends.
module data_mem_sync #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_sync_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic             rd;
    logic [1:0]       size;
    logic             sext;
    logic [IDX_W-1:0] idx;
    logic             err;
  } req_t;

  logic [7:0]    mem_q [DEPTH];
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  req_t          req_q, req_d;
  req_t          cur, src;
  logic          resp_valid_q, resp_valid_d;
  logic          err_q, err_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          req_ready, accept;
  logic [2:0]    nbytes;
  logic [ADDR_W:0] last_addr;
  logic          oor, align_err;

  assign req_ready      = (state_q == IDLE) && !rst;
  assign accept         = bus.req_valid && req_ready;
  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.err        = err_q;
  assign bus.rd_data    = rd_data_q;

  function automatic logic [31:0] load_val(input req_t r);
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] v;
    b0 = mem_q[r.idx];
    b1 = mem_q[r.idx + IDX_W'(1)];
    b2 = mem_q[r.idx + IDX_W'(2)];
    b3 = mem_q[r.idx + IDX_W'(3)];
    case (r.size)
      2'b00:   v = {{24{r.sext & b0[7]}}, b0};
      2'b01:   v = {{16{r.sext & b0[7]}}, b0, b1};
      default: v = {b0, b1, b2, b3};
    endcase
    if (!r.rd || r.err) v = 32'd0;
    return v;
  endfunction

  // Decode the live request; range is checked on the raw address so accesses never wrap.
  always_comb begin
    case (bus.size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    last_addr = {1'b0, bus.addr_in} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
    oor       = last_addr >= (ADDR_W+1)'(DEPTH);
    cur       = '0;
    cur.rd    = bus.mem_rd;
    cur.size  = bus.size;
    cur.sext  = bus.sign_ext;
    cur.idx   = bus.addr_in[IDX_W-1:0];
`ifdef DATA_MEM_ALIGN_CHK_EN
    align_err = (bus.size == 2'b01 && bus.addr_in[0]) ||
                (bus.size == 2'b10 && bus.addr_in[1:0] != 2'b00);
`else
    align_err = 1'b0;
    if (bus.size == 2'b01) cur.idx[0] = 1'b0;
    if (bus.size == 2'b10) cur.idx[1:0] = 2'b00;
`endif
    cur.err = (bus.mem_rd && bus.mem_wr) || (bus.size == 2'b11) || oor || align_err;
  end

  // Memory is stable while busy, so a zero-wait load reads the live request at the accept edge.
  assign src = (state_q == IDLE) ? cur : req_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    resp_valid_d = 1'b0;
    err_d        = err_q;
    rd_data_d    = rd_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = cur;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == RESP && state_q != RESP) begin
      resp_valid_d = 1'b1;
      err_d        = src.err;
      rd_data_d    = load_val(src);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_q        <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rd_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Stores commit on the accept edge; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (accept && bus.mem_wr && !cur.err) begin
      case (bus.size)
        2'b00: mem_q[cur.idx] <= bus.wr_data[7:0];
        2'b01: begin
          mem_q[cur.idx]              <= bus.wr_data[15:8];
          mem_q[cur.idx + IDX_W'(1)]  <= bus.wr_data[7:0];
        end
        default: begin
          mem_q[cur.idx]              <= bus.wr_data[31:24];
          mem_q[cur.idx + IDX_W'(1)]  <= bus.wr_data[23:16];
          mem_q[cur.idx + IDX_W'(2)]  <= bus.wr_data[15:8];
          mem_q[cur.idx + IDX_W'(3)]  <= bus.wr_data[7:0];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_sync.sv
// Bench for data_mem_sync: three instances (WAIT_CYCLES 0, 3, 2) against a byte-array reference model.
module tb_data_mem_sync;
  logic        clk;
  logic [2:0]  rst;
  int          sel;
  logic        req_valid, mem_rd, mem_wr, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr_in, wr_data;
  logic        ready_m, resp_m, err_m;
  logic [31:0] rd_m;
  int          n_tests, n_fail;
  logic [7:0]  mdl [3][256];
  int          wcyc [3] = '{0, 3, 2};

  data_mem_sync_if #(.ADDR_W(32)) if0 ();
  data_mem_sync_if #(.ADDR_W(32)) if1 ();
  data_mem_sync_if #(.ADDR_W(32)) if2 ();

  data_mem_sync #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst[0]), .bus(if0.slave));
  data_mem_sync #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(3)) u1 (.clk(clk), .rst(rst[1]), .bus(if1.slave));
  data_mem_sync #(.DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(2)) u2 (.clk(clk), .rst(rst[2]), .bus(if2.slave));

  assign if0.req_valid = req_valid && (sel == 0);
  assign if1.req_valid = req_valid && (sel == 1);
  assign if2.req_valid = req_valid && (sel == 2);
  assign if0.mem_rd = mem_rd;     assign if1.mem_rd = mem_rd;     assign if2.mem_rd = mem_rd;
  assign if0.mem_wr = mem_wr;     assign if1.mem_wr = mem_wr;     assign if2.mem_wr = mem_wr;
  assign if0.addr_in = addr_in;   assign if1.addr_in = addr_in;   assign if2.addr_in = addr_in;
  assign if0.size = size;         assign if1.size = size;         assign if2.size = size;
  assign if0.sign_ext = sign_ext; assign if1.sign_ext = sign_ext; assign if2.sign_ext = sign_ext;
  assign if0.wr_data = wr_data;   assign if1.wr_data = wr_data;   assign if2.wr_data = wr_data;

  always_comb begin
    case (sel)
      1:       begin ready_m = if1.req_ready; resp_m = if1.resp_valid; err_m = if1.err; rd_m = if1.rd_data; end
      2:       begin ready_m = if2.req_ready; resp_m = if2.resp_valid; err_m = if2.err; rd_m = if2.rd_data; end
      default: begin ready_m = if0.req_ready; resp_m = if0.resp_valid; err_m = if0.err; rd_m = if0.rd_data; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: expected err/rd_data from the access rules, updating the byte array on a good store.
  task automatic model_op(input int d, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] er, output logic ee);
    int nb, mis, ea;
    longint last;
    logic [31:0] v, t;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis  = (sz == 2'd1) ? int'(a % 2) : (sz == 2'd2) ? int'(a % 4) : 0;
    last = longint'({32'd0, a}) + nb - 1;
    ee   = (rd && wr) || (sz == 2'd3) || (last >= 256);
`ifdef DATA_MEM_ALIGN_CHK_EN
    if (mis != 0) ee = 1'b1;
    ea = int'(a % 256);
`else
    ea = int'(a % 256) - mis;
`endif
    er = 32'd0;
    if (!ee && wr) begin
      for (int i = 0; i < nb; i++) begin
        t = wd >> (8 * (nb - 1 - i));
        mdl[d][ea + i] = t[7:0];
      end
    end else if (!ee && rd) begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = (v << 8) | {24'd0, mdl[d][ea + i]};
      if (sx && nb < 4 && v[8 * nb - 1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      er = v;
    end
  endtask

  // Drive one request to instance d, scramble inputs after accept, report what came back.
  task automatic access(input int d, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] got, output logic gerr,
                        output bit busy_rdy, output bit post_bad);
    int k;
    got = 32'd0; gerr = 1'b0; busy_rdy = 1'b0; post_bad = 1'b0; lat = -1;
    @(negedge clk);
    sel = d; req_valid = 1'b1; mem_rd = rd; mem_wr = wr; size = sz; sign_ext = sx;
    addr_in = a; wr_data = wd;
    #1;
    k = 0;
    while (!ready_m && k < 20) begin @(negedge clk); k++; end
    if (!ready_m) begin req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0; mem_rd = 1'($urandom); mem_wr = 1'($urandom); size = 2'($urandom);
    sign_ext = 1'($urandom); addr_in = $urandom; wr_data = $urandom;
    k = 0;
    do begin
      @(negedge clk); k++;
      if (ready_m) busy_rdy = 1'b1;
    end while (!resp_m && k < 40);
    if (!resp_m) return;
    lat = k; got = rd_m; gerr = err_m;
    @(negedge clk);
    post_bad = resp_m || !ready_m || (rd_m !== got) || (err_m !== gerr);
  endtask

  // Access plus full comparison against the model; name tags the FAIL lines.
  task automatic chk_access(input string nm, input int d, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic sx, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] got, output logic gerr);
    logic [31:0] er; logic ee; int lat; bit br, pb;
    model_op(d, rd, wr, sz, sx, a, wd, er, ee);
    access(d, rd, wr, sz, sx, a, wd, lat, got, gerr, br, pb);
    n_tests++; if (lat !== wcyc[d] + 1) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, wcyc[d] + 1); end
    n_tests++; if (br !== 1'b0) begin n_fail++; $display("FAIL %s ready_while_busy: got 1 expected 0", nm); end
    n_tests++; if (pb !== 1'b0) begin n_fail++; $display("FAIL %s after_resp (pulse/ready/hold): got bad expected clean", nm); end
    n_tests++; if (gerr !== ee) begin n_fail++; $display("FAIL %s err: got %0b expected %0b", nm, gerr, ee); end
    n_tests++; if (got !== er) begin n_fail++; $display("FAIL %s rd_data: got %h expected %h", nm, got, er); end
  endtask

  task automatic test_reset;
    rst = 3'b111;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d; #1;
      n_tests++; if (ready_m !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 0", d, ready_m); end
      n_tests++; if (resp_m !== 1'b0) begin n_fail++; $display("FAIL reset_resp[%0d]: got %b expected 0", d, resp_m); end
      n_tests++; if (err_m !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b expected 0", d, err_m); end
      n_tests++; if (rd_m !== 32'd0) begin n_fail++; $display("FAIL reset_rd[%0d]: got %h expected 0", d, rd_m); end
    end
    @(posedge clk); #1; rst = 3'b000;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d; #1;
      n_tests++; if (ready_m !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready[%0d]: got %b expected 1", d, ready_m); end
    end
  endtask

  task automatic preload;
    logic [31:0] g; logic e;
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 64; w++) chk_access("preload", d, 1'b0, 1'b1, 2'd2, 1'b0, 32'(4 * w), $urandom, g, e);
  endtask

  task automatic test_word_round_trip;
    logic [31:0] g; logic e;
    chk_access("rt_store", 0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, g, e);
    chk_access("rt_load_word", 0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, g, e);
    n_tests++; if (g !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rt_word_literal: got %h expected deadbeef", g); end
    chk_access("rt_load_byte", 0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, g, e);
    n_tests++; if (g !== 32'h000000DE) begin n_fail++; $display("FAIL rt_byte_literal: got %h expected 000000de", g); end
  endtask

  task automatic test_subword;
    logic [31:0] g; logic e;
    chk_access("sw_store_b", 0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h00000080, g, e);
    chk_access("sw_lb_sx", 0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, g, e);
    n_tests++; if (g !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sext_literal: got %h expected ffffff80", g); end
    chk_access("sw_lb_zx", 0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, g, e);
    n_tests++; if (g !== 32'h00000080) begin n_fail++; $display("FAIL lb_zext_literal: got %h expected 00000080", g); end
    chk_access("sw_store_h", 0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, g, e);
    chk_access("sw_lh_sx", 0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, g, e);
    n_tests++; if (g !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_sext_literal: got %h expected ffff8001", g); end
  endtask

  task automatic test_wait_states;
    logic [31:0] g; logic e;
    chk_access("ws_store", 1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'hA5C3_0F96, g, e);
    chk_access("ws_load", 1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, g, e);
    n_tests++; if (g !== 32'hA5C30F96) begin n_fail++; $display("FAIL ws_literal: got %h expected a5c30f96", g); end
  endtask

  task automatic test_errors;
    logic [31:0] g; logic e;
    chk_access("err_rdwr", 0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, g, e);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_rdwr_flag: got %b expected 1", e); end
    chk_access("err_size3", 0, 1'b0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678, g, e);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_size3_flag: got %b expected 1", e); end
    chk_access("err_rb10", 0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, g, e);
    n_tests++; if (g !== 32'hDEADBEEF) begin n_fail++; $display("FAIL err_mem_changed: got %h expected deadbeef", g); end
    chk_access("err_oor", 0, 1'b0, 1'b1, 2'd2, 1'b0, 32'hFE, 32'h55AA55AA, g, e);
    n_tests++; if (e !== 1'b1 || g !== 32'd0) begin n_fail++; $display("FAIL err_oor: got err=%b rd=%h expected err=1 rd=0", e, g); end
    chk_access("err_rbFE", 0, 1'b1, 1'b0, 2'd1, 1'b0, 32'hFE, 32'h0, g, e);
  endtask

  task automatic test_alignment;
    logic [31:0] g; logic e;
    chk_access("al_store", 0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h05, 32'h11223344, g, e);
`ifdef DATA_MEM_ALIGN_CHK_EN
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL align_err: got %b expected 1", e); end
    chk_access("al_rb", 0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, g, e);
`else
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL align_err: got %b expected 0", e); end
    chk_access("al_rb", 0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, g, e);
    n_tests++; if (g !== 32'h11223344) begin n_fail++; $display("FAIL align_down_literal: got %h expected 11223344", g); end
`endif
  endtask

  task automatic test_back_to_back;
    int hits [$];
    bit prev, dbl, bad_dat;
    @(negedge clk);
    sel = 1; req_valid = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; size = 2'd2; addr_in = 32'h8;
    prev = 1'b0; dbl = 1'b0; bad_dat = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (resp_m) begin
        hits.push_back(c);
        if (prev) dbl = 1'b1;
        if (rd_m !== 32'd0 || err_m !== 1'b0) bad_dat = 1'b1;
      end
      prev = resp_m;
    end
    req_valid = 1'b0;
    n_tests++; if (hits.size() < 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected >=3", hits.size()); end
    else begin
      n_tests++; if (hits[1] - hits[0] !== wcyc[1] + 2) begin n_fail++; $display("FAIL b2b_gap: got %0d expected %0d", hits[1] - hits[0], wcyc[1] + 2); end
      n_tests++; if (hits[2] - hits[1] !== wcyc[1] + 2) begin n_fail++; $display("FAIL b2b_gap2: got %0d expected %0d", hits[2] - hits[1], wcyc[1] + 2); end
    end
    n_tests++; if (dbl !== 1'b0) begin n_fail++; $display("FAIL b2b_double_pulse: got 1 expected 0"); end
    n_tests++; if (bad_dat !== 1'b0) begin n_fail++; $display("FAIL b2b_noop_data: got nonzero expected rd=0 err=0"); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0] g; logic e; bit saw; int k;
    chk_access("rm_store", 2, 1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, g, e);
    chk_access("rm_load", 2, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, g, e);
    @(negedge clk);
    sel = 2; req_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; size = 2'd2; addr_in = 32'h40; #1;
    k = 0;
    while (!ready_m && k < 20) begin @(negedge clk); k++; end
    n_tests++; if (ready_m !== 1'b1) begin n_fail++; $display("FAIL rm_accept: got ready=%b expected 1", ready_m); end
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); rst[2] = 1'b1;
    saw = 1'b0;
    repeat (3) begin @(negedge clk); if (resp_m) saw = 1'b1; end
    n_tests++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rm_resp_in_reset: got 1 expected 0"); end
    n_tests++; if (rd_m !== 32'd0 || err_m !== 1'b0 || ready_m !== 1'b0) begin
      n_fail++; $display("FAIL rm_outputs: got rd=%h err=%b rdy=%b expected 0/0/0", rd_m, err_m, ready_m); end
    @(posedge clk); #1; rst[2] = 1'b0;
    @(negedge clk);
    n_tests++; if (ready_m !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after: got %b expected 1", ready_m); end
    saw = 1'b0;
    repeat (4) begin if (resp_m) saw = 1'b1; @(negedge clk); end
    n_tests++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rm_late_resp: got 1 expected 0"); end
    chk_access("rm_readback", 2, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, g, e);
    n_tests++; if (g !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rm_readback_literal: got %h expected cafef00d", g); end
  endtask

  task automatic test_random;
    logic [31:0] g, a; logic e; int op, sr, ar, d;
    logic [1:0] sz;
    for (int n = 0; n < 300; n++) begin
      d  = $urandom_range(0, 2);
      op = $urandom_range(0, 7);
      sr = $urandom_range(0, 7);
      sz = (sr == 7) ? 2'd3 : 2'(sr % 3);
      ar = $urandom_range(0, 9);
      a  = (ar < 8) ? 32'($urandom_range(0, 255)) : (ar == 8) ? 32'($urandom_range(250, 255)) : $urandom;
      chk_access("random", d, (op <= 2) || (op == 7), (op >= 3 && op <= 5) || (op == 7),
                 sz, 1'($urandom), a, $urandom, g, e);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; sel = 0;
    req_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr_in = 32'd0; wr_data = 32'd0; rst = 3'b111;
    test_reset;
    preload;
    test_word_round_trip;
    test_subword;
    test_wait_states;
    test_errors;
    test_alignment;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
